seq_divider: RTL and testbench

- Parametrised, multi-cycle signed integer divider; next generation of the single-cycle 32-bit combinational divider.
- Uses a radix-2 restoring algorithm on magnitudes, then applies a sign fix-up. Throughput is one division per WIDTH+2 cycles, with a start/busy/done handshake.
- Sits beside the multiplier in the ALU. Result packing matches the existing HI/LO convention: remainder in the upper half, quotient in the lower half.

---
 rtl/div_pkg.sv | 16 +
 rtl/seq_divider_step.sv | 20 ++
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared state type, divide-by-zero pattern and magnitude helper for seq_divider.
// Operands up to MAX_W bits are supported by the helper.
package div_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    localparam logic [MAX_W-1:0] DIV0_QUO = '1;

    // Caller sign-extends its operand to MAX_W bits and truncates the result back.
    function automatic logic [MAX_W-1:0] abs_op(input logic [MAX_W-1:0] v);
        return v[MAX_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One radix-2 restoring division iteration on magnitudes (purely combinational).
module seq_divider_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic             w_fit;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_fit   = (w_shift >= {2'b00, i_dvsr});
    assign o_rem   = w_fit ? (WIDTH+1)'(w_shift - {2'b00, i_dvsr}) : w_shift[WIDTH:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_fit};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider, z = {remainder, quotient}, WIDTH+2 cycles per operation.
// Define SEQ_DIVIDER_UNSIGNED_EN to add the i_is_signed port for unsigned operation.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    input  logic               i_is_signed,
`endif
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_dividend,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_z,
    output logic               o_div_by_zero
);

    localparam int unsigned    CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg_dvd;
    logic               r_neg_dvs;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_z;
    logic               r_dbz;

    logic               w_signed;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    assign w_signed = i_is_signed;
`else
    assign w_signed = 1'b1;
`endif

    assign w_dvd_mag = w_signed ? WIDTH'(abs_op(MAX_W'($signed(i_dividend)))) : i_dividend;
    assign w_dvs_mag = w_signed ? WIDTH'(abs_op(MAX_W'($signed(i_divisor))))  : i_divisor;

    // Remainder follows the dividend's sign; quotient is negative when signs differ.
    assign w_quo_fix = (r_neg_dvd ^ r_neg_dvs) ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_dvd ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_neg_dvd <= 1'b0;
            r_neg_dvs <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_z       <= '0;
            r_dbz     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        if (i_divisor == '0) begin
                            r_z     <= {i_dividend, DIV0_QUO[WIDTH-1:0]};
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_neg_dvd <= w_signed & i_dividend[WIDTH-1];
                            r_neg_dvs <= w_signed & i_divisor[WIDTH-1];
                            r_rem     <= '0;
                            r_quo     <= w_dvd_mag;
                            r_dvsr    <= w_dvs_mag;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= CALC;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_z     <= {w_rem_fix, w_quo_fix};
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_z           = r_z;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32) against a 64-bit arithmetic reference.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] z;
    logic        dbz;

    int checks;
    int errors;

    seq_divider #(
        .WIDTH (32)
    ) dut (
`ifdef SEQ_DIVIDER_UNSIGNED_EN
        .i_is_signed   (1'b1),
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_z           (z),
        .o_div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed division done in 64-bit arithmetic, truncated to 32 bits.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output logic dz);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            dz = 1'b1;
            return {a, 32'hFFFF_FFFF};
        end
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one operation; lat = edges after the accept edge until done is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] zo, output logic dzo,
                         output int lat, output int bcnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        zo  = z;
        dzo = dbz;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (z !== 64'd0) begin errors++; $display("FAIL reset_z got %h want 0", z); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", dbz); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic [63:0] tz [6];
        logic        td [6];
        logic [63:0] zo;
        logic        dzo;
        int          lat;
        int          bcnt;
        ta[0] = 32'd100;        tb[0] = 32'd7;          tz[0] = 64'h00000002_0000000E; td[0] = 0;
        ta[1] = -32'sd100;      tb[1] = 32'd7;          tz[1] = 64'hFFFFFFFE_FFFFFFF2; td[1] = 0;
        ta[2] = 32'd100;        tb[2] = -32'sd7;        tz[2] = 64'h00000002_FFFFFFF2; td[2] = 0;
        ta[3] = 32'h8000_0000;  tb[3] = 32'hFFFF_FFFF;  tz[3] = 64'h00000000_80000000; td[3] = 0;
        ta[4] = 32'd5;          tb[4] = 32'd0;          tz[4] = 64'h00000005_FFFFFFFF; td[4] = 1;
        ta[5] = 32'd9;          tb[5] = 32'd3;          tz[5] = 64'h00000000_00000003; td[5] = 0;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], zo, dzo, lat, bcnt);
            checks++;
            if (zo !== tz[i]) begin
                errors++; $display("FAIL dir%0d_z got %h want %h", i, zo, tz[i]);
            end
            checks++;
            if (dzo !== td[i]) begin
                errors++; $display("FAIL dir%0d_dbz got %b want %b", i, dzo, td[i]);
            end
            checks++;
            if (lat != (td[i] ? 0 : 33)) begin
                errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, td[i] ? 0 : 33);
            end
            checks++;
            if (bcnt != (td[i] ? 0 : 33)) begin
                errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, td[i] ? 0 : 33);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] zo;
        logic [63:0] ze;
        logic        dzo;
        logic        dze;
        int          lat;
        int          bcnt;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 300)) - 32'd150;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            ze = ref_div(a, b, dze);
            do_op(a, b, zo, dzo, lat, bcnt);
            checks++;
            if (zo !== ze) begin
                errors++; $display("FAIL rnd%0d_z a=%h b=%h got %h want %h", i, a, b, zo, ze);
            end
            checks++;
            if (dzo !== dze) begin
                errors++; $display("FAIL rnd%0d_dbz got %b want %b", i, dzo, dze);
            end
            checks++;
            if (lat != (dze ? 0 : 33)) begin
                errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, dze ? 0 : 33);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] ze;
        logic [63:0] zc;
        logic        dze;
        int          ndone;
        ze = ref_div(32'd1000, 32'd9, dze);
        zc = '0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                ndone++;
                zc = z;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL busy_ignore_done_count got %0d want 1", ndone); end
        checks++;
        if (zc !== ze) begin errors++; $display("FAIL busy_ignore_z got %h want %h", zc, ze); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd123456;
        divisor  = -32'sd789;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (z !== 64'd0) begin errors++; $display("FAIL midrst_z got %h want 0", z); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL midrst_dbz got %b want 0", dbz); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ze;
        logic        dze;
        int          lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = -32'sd1000;
        divisor  = 32'd33;
        ze = ref_div(dividend, divisor, dze);
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
        checks++;
        if (z !== ze) begin errors++; $display("FAIL b2b_first_z got %h want %h", z, ze); end
        dividend = 32'd7777;
        divisor  = -32'sd3;
        ze = ref_div(dividend, divisor, dze);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_no_bubble got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
        checks++;
        if (z !== ze) begin errors++; $display("FAIL b2b_second_z got %h want %h", z, ze); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
